moore_pattern_tx: RTL and testbench

//  Moore-style serial pattern transmitter: emits a programmable W-bit pattern, MSB first,
//  one bit per clock, repeated N times with an optional idle gap between repeats.

---
 rtl/moore_pattern_tx_if.sv | 13 +
 rtl/moore_pattern_tx.sv | 72 +++++++
 tb/tb_moore_pattern_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/moore_pattern_tx_if.sv
// moore_pattern_tx_if: request fields and serial outputs of the pattern transmitter.
interface moore_pattern_tx_if #(parameter int W = 3, parameter int CNT_W = 4);
  logic             start;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] repeats;
  logic [CNT_W-1:0] gap_len;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  modport master (output start, pattern, repeats, gap_len, input ser_out, ser_valid, busy, done);
  modport slave  (input start, pattern, repeats, gap_len, output ser_out, ser_valid, busy, done);
endinterface

// File: rtl/moore_pattern_tx.sv
// moore_pattern_tx: repeats a W-bit pattern MSB first with optional idle gaps; Moore outputs.
module moore_pattern_tx #(
  parameter int W     = 3,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  moore_pattern_tx_if.slave bus
);
  localparam int IW = (W > 2) ? $clog2(W) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3;
  logic [1:0]       state, state_n;
  logic [W-1:0]     pat, pat_n;
  logic [IW-1:0]    idx, idx_n;
  logic [CNT_W-1:0] rep, rep_n, gap, gap_n, gcnt, gcnt_n;
  always_comb begin
    state_n = state;
    pat_n   = pat;
    idx_n   = idx;
    rep_n   = rep;
    gap_n   = gap;
    gcnt_n  = gcnt;
    case (state)
      IDLE: if (bus.start) begin
        pat_n   = bus.pattern;
        rep_n   = bus.repeats;
        gap_n   = bus.gap_len;
        idx_n   = IW'(W - 1);
        state_n = (bus.repeats == '0) ? DONE : SHIFT;
      end
      SHIFT: if (idx == '0) begin
        rep_n   = rep - CNT_W'(1);
        idx_n   = IW'(W - 1);
        gcnt_n  = gap;
        state_n = (rep == CNT_W'(1)) ? DONE : (gap == '0) ? SHIFT : GAP;
      end else begin
        idx_n = idx - IW'(1);
      end
      GAP: begin
        gcnt_n  = gcnt - CNT_W'(1);
        state_n = (gcnt == CNT_W'(1)) ? SHIFT : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so the first bit lands one cycle after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pat           <= '0;
      idx           <= '0;
      rep           <= '0;
      gap           <= '0;
      gcnt          <= '0;
      bus.ser_out   <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      pat           <= pat_n;
      idx           <= idx_n;
      rep           <= rep_n;
      gap           <= gap_n;
      gcnt          <= gcnt_n;
      bus.ser_out   <= (state_n == SHIFT) && pat_n[idx_n];
      bus.ser_valid <= state_n == SHIFT;
      bus.busy      <= (state_n == SHIFT) || (state_n == GAP);
      bus.done      <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_moore_pattern_tx.sv
// tb_moore_pattern_tx: scoreboard bench; expected per-cycle output streams come from a pattern/gap model.
module tb_moore_pattern_tx;
  localparam int W = 3;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [3:0] q[$];
  moore_pattern_tx_if #(.W(W), .CNT_W(CNT_W)) bus ();
  moore_pattern_tx #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void push_expect(input logic [W-1:0] p, input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int b = W - 1; b >= 0; b--) q.push_back({1'b1, 1'b1, p[b], 1'b0});
      if (k < r - 1) for (int j = 0; j < g; j++) q.push_back(4'b1000);
    end
    q.push_back(4'b0001);
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin
    logic [3:0] got;
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        got = {bus.busy, bus.ser_valid, bus.ser_out, bus.done};
        if (bus.busy || bus.ser_valid || bus.done) begin
          if (q.size() == 0) check("unexpected_output", int'(got), 0);
          else begin
            exp = q.pop_front();
            check("stream", int'(got), int'(exp));
          end
        end else check("idle_ser_out", int'(bus.ser_out), 0);
      end
    end
  end

  task automatic send(input logic [W-1:0] p, input int r, input int g, input bit inject);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = p;
    bus.repeats = CNT_W'(r);
    bus.gap_len = CNT_W'(g);
    push_expect(p, r, g);
    @(negedge clk);
    bus.start = 1'b0;
    bus.pattern = W'($urandom);
    bus.repeats = CNT_W'($urandom);
    bus.gap_len = CNT_W'($urandom);
    lat = 1;
    while (!bus.done && lat < 400) begin
      bus.start = inject && lat == 2;
      if (inject && lat == 2) bus.pattern = ~p;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("latency", lat, (r == 0) ? 1 : 1 + r * W + (r - 1) * g);
  endtask

  initial begin
    int t;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.repeats = '0;
    bus.gap_len = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.busy, bus.ser_valid, bus.ser_out, bus.done}), 0);
    rst = 1'b0;
    send(3'b101, 1, 0, 1'b0);
    send(3'b101, 3, 0, 1'b0);
    send(3'b110, 2, 2, 1'b0);
    send(3'b111, 0, 5, 1'b0);
    send(3'b011, 3, 1, 1'b1);
    send(3'b100, 15, 0, 1'b0);
    send(3'b001, 2, 15, 1'b0);
    // Abort during the second of three repeats.
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 3'b101;
    bus.repeats = 4'd3;
    bus.gap_len = 4'd0;
    push_expect(3'b101, 3, 0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 1) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    check("async_reset_outputs", int'({bus.busy, bus.ser_valid, bus.ser_out, bus.done}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(3'b101, 2, 1, 1'b0);
    // Start held high: back-to-back transfers separated by one IDLE cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 3'b110;
    bus.repeats = 4'd1;
    bus.gap_len = 4'd0;
    push_expect(3'b110, 1, 0);
    push_expect(3'b110, 1, 0);
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    bus.start = 1'b0;
    check("held_start_cycles", t, 2 * (1 + W) + 1);
    for (int i = 0; i < 30; i++)
      send(W'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), i % 5 == 0);
    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
